// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the common data bus: widths, broadcast record, index helper.
package cdb_arbiter_pkg;

   localparam int TAG_W  = 3;
   localparam int DATA_W = 32;

   // One broadcast as seen by the reservation stations and the RAT.
   typedef struct packed {
      logic              valid;
      logic [TAG_W-1:0]  tag;
      logic [DATA_W-1:0] value;
   } cdb_bcast_t;

   // (base + off) mod n for base < n and off <= n; avoids a divider in the scan.
   function automatic int wrap_add(input int base, input int off, input int n);
      int s;
      s = base + off;
      if (s >= n) begin
         s = s - n;
      end
      return s;
   endfunction

endpackage

// File: rtl/result_fifo.sv
// Per-source result buffer holding {tag, value}; head is visible combinationally.
module result_fifo #(
   parameter int DEPTH  = 2,
   parameter int TAG_W  = 3,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic [TAG_W-1:0]  tag_i,
   input  logic [DATA_W-1:0] value_i,
   output logic [TAG_W-1:0]  head_tag_o,
   output logic [DATA_W-1:0] head_value_o,
   output logic              full_o,
   output logic              empty_o
);
   import cdb_arbiter_pkg::*;

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [TAG_W+DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]        count_q, count_d;
   logic                    do_push, do_pop;

   assign full_o  = (count_q == FULL_CNT);
   assign empty_o = (count_q == '0);
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign {head_tag_o, head_value_o} = mem_q[rd_ptr_q];

   // Next pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Pointer/count registers; reset discards everything buffered.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage write; contents need no reset because count gates visibility.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= {tag_i, value_i};
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: buffers results per source, broadcasts up to two per cycle round-robin.
module cdb_arbiter #(
   parameter int NUM_SRC    = 3,
   parameter int TAG_W      = 3,
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_SRC-1:0]        src_valid,
   input  logic [NUM_SRC*TAG_W-1:0]  src_tag,
   input  logic [NUM_SRC*DATA_W-1:0] src_value,
   output logic [NUM_SRC-1:0]        src_ready,
   output logic                      cdb0_valid,
   output logic [TAG_W-1:0]          cdb0_tag,
   output logic [DATA_W-1:0]         cdb0_value,
   output logic                      cdb1_valid,
   output logic [TAG_W-1:0]          cdb1_tag,
   output logic [DATA_W-1:0]         cdb1_value
);
   import cdb_arbiter_pkg::*;

   localparam int RR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   logic [NUM_SRC-1:0] fifo_full, fifo_empty, pop;
   logic [TAG_W-1:0]   head_tag   [NUM_SRC];
   logic [DATA_W-1:0]  head_value [NUM_SRC];

   logic [RR_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [RR_W-1:0]    scan_idx, g0_idx, g1_idx;
   logic               g0_found, g1_found;

   logic               cdb0_valid_q, cdb0_valid_d, cdb1_valid_q, cdb1_valid_d;
   logic [TAG_W-1:0]   cdb0_tag_q, cdb0_tag_d, cdb1_tag_q, cdb1_tag_d;
   logic [DATA_W-1:0]  cdb0_value_q, cdb0_value_d, cdb1_value_q, cdb1_value_d;

   // Ready reflects registered occupancy only, so a full buffer stalls even while draining.
   assign src_ready = rst ? '0 : ~fifo_full;

   generate
      for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_fifo
         result_fifo #(
            .DEPTH  (FIFO_DEPTH),
            .TAG_W  (TAG_W),
            .DATA_W (DATA_W)
         ) u_fifo (
            .clk          (clk),
            .rst          (rst),
            .push_i       (src_valid[gi] & src_ready[gi]),
            .pop_i        (pop[gi]),
            .tag_i        (src_tag[gi*TAG_W +: TAG_W]),
            .value_i      (src_value[gi*DATA_W +: DATA_W]),
            .head_tag_o   (head_tag[gi]),
            .head_value_o (head_value[gi]),
            .full_o       (fifo_full[gi]),
            .empty_o      (fifo_empty[gi])
         );
      end
   endgenerate

   // Round-robin scan from rr_ptr: first non-empty source to port 0, second to port 1.
   always_comb begin
      g0_found = 1'b0;
      g1_found = 1'b0;
      g0_idx   = '0;
      g1_idx   = '0;
      scan_idx = '0;
      pop      = '0;
      rr_ptr_d = rr_ptr_q;
      for (int k = 0; k < NUM_SRC; k++) begin
         scan_idx = RR_W'(wrap_add(int'(rr_ptr_q), k, NUM_SRC));
         if (!fifo_empty[scan_idx]) begin
            if (!g0_found) begin
               g0_found = 1'b1;
               g0_idx   = scan_idx;
            end else if (!g1_found) begin
               g1_found = 1'b1;
               g1_idx   = scan_idx;
            end
         end
      end
      if (g0_found) begin
         pop[g0_idx] = 1'b1;
      end
      if (g1_found) begin
         pop[g1_idx] = 1'b1;
      end
      if (g1_found) begin
         rr_ptr_d = RR_W'(wrap_add(int'(g1_idx), 1, NUM_SRC));
      end else if (g0_found) begin
         rr_ptr_d = RR_W'(wrap_add(int'(g0_idx), 1, NUM_SRC));
      end
   end

   // Broadcast payloads; an ungranted port carries all zeros.
   always_comb begin
      cdb0_valid_d = g0_found;
      cdb0_tag_d   = g0_found ? head_tag[g0_idx]   : '0;
      cdb0_value_d = g0_found ? head_value[g0_idx] : '0;
      cdb1_valid_d = g1_found;
      cdb1_tag_d   = g1_found ? head_tag[g1_idx]   : '0;
      cdb1_value_d = g1_found ? head_value[g1_idx] : '0;
   end

   // Output registers and round-robin pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q     <= '0;
         cdb0_valid_q <= 1'b0;
         cdb0_tag_q   <= '0;
         cdb0_value_q <= '0;
         cdb1_valid_q <= 1'b0;
         cdb1_tag_q   <= '0;
         cdb1_value_q <= '0;
      end else begin
         rr_ptr_q     <= rr_ptr_d;
         cdb0_valid_q <= cdb0_valid_d;
         cdb0_tag_q   <= cdb0_tag_d;
         cdb0_value_q <= cdb0_value_d;
         cdb1_valid_q <= cdb1_valid_d;
         cdb1_tag_q   <= cdb1_tag_d;
         cdb1_value_q <= cdb1_value_d;
      end
   end

   assign cdb0_valid = cdb0_valid_q;
   assign cdb0_tag   = cdb0_tag_q;
   assign cdb0_value = cdb0_value_q;
   assign cdb1_valid = cdb1_valid_q;
   assign cdb1_tag   = cdb1_tag_q;
   assign cdb1_value = cdb1_value_q;

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Common Data Bus arbiter for the 2-wide out-of-order core. Sits directly downstream of the functional units (adder, multiplier, load unit) and upstream of the reservation stations, register alias table and register file. It buffers completed results per source and broadcasts up to two tag/value pairs per cycle, which wakes dependent reservation-station entries and clears RAT tags.

## Interface
Parameters:
- NUM_SRC, 3: result sources; index 0 = adder, 1 = multiplier, 2 = load unit.
- TAG_W, 3: reservation-station tag width (8 RS).
- DATA_W, 32: result value width.
- FIFO_DEPTH, 2: per-source result buffer depth; power of two, ≥2.

Ports:
- clk  in  1  system clock; single clock domain, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- src_valid  in  NUM_SRC  source i presents a result.
- src_tag  in  NUM_SRC*TAG_W  packed RS tags; source i at bits [i*TAG_W +: TAG_W].
- src_value  in  NUM_SRC*DATA_W  packed results; same packing rule.
- src_ready  out  NUM_SRC  buffer i can accept; a push occurs on src_valid[i] & src_ready[i].
- cdb0_valid / cdb0_tag / cdb0_value  out  1 / TAG_W / DATA_W  broadcast port 0, registered.
- cdb1_valid / cdb1_tag / cdb1_value  out  1 / TAG_W / DATA_W  broadcast port 1, registered.

## Operation
- One FIFO per source, FIFO_DEPTH entries of {tag, value}, with a count and read/write pointers of log2(FIFO_DEPTH) bits.
- Pointers wrap modulo FIFO_DEPTH.
- src_ready[i] = !rst && (count_i < FIFO_DEPTH). It depends on the registered count only, never on a same-cycle pop. A full FIFO therefore deasserts ready even while it drains.
- A source must hold tag and value stable while valid is high and ready is low. Nothing is dropped.
- Arbitration runs every cycle over non-empty FIFOs, round-robin, starting at rr_ptr:
  - The first non-empty index found (rr_ptr, rr_ptr+1, … mod NUM_SRC) is granted to port 0.
  - The second is granted to port 1.
  - A source receives at most one grant per cycle.
- Each granted FIFO pops its head that cycle. The head is written into the port's output register.
- An ungranted port drives valid = 0 with tag and value = 0.
- rr_ptr update:
  - becomes (index of last grant + 1) mod NUM_SRC;
  - is unchanged when nothing is granted.
- No backpressure from consumers. The RS, RAT and register file always accept both broadcasts.
- Two broadcasts never carry the same source in one cycle. Tag uniqueness is owned by the dispatch unit.
- Per-source ordering is FIFO. Ordering across sources is not guaranteed.
- Simultaneous push and pop on one FIFO in the same cycle: count unchanged, both pointers advance.

## Timing
- Reset values:
  - all counts and pointers = 0;
  - rr_ptr = 0;
  - cdb0_*/cdb1_* = 0;
  - src_ready = 0 while rst = 1, then all ones the cycle after rst deasserts.
- No same-cycle bypass from push to arbitration:
  - push in cycle t;
  - entry visible and arbitrated in t+1;
  - cdb*_valid high in t+2.
- Minimum latency is therefore 2 cycles.
- Sustained throughput is 2 broadcasts per cycle.
- With all NUM_SRC sources continuously non-empty, each source is granted at least 2 of every 3 cycles.
- rst asserted mid-operation:
  - all buffered results are discarded, never broadcast;
  - outputs are 0 from the cycle after the rst edge.

## Structure
- Shared package InstructionPKG gains:
  - constants TAG_W and DATA_W;
  - typedef cdb_bcast_t {logic valid; logic [TAG_W-1:0] tag; logic [DATA_W-1:0] value;}.
- The RS and RAT consume cdb_bcast_t.
- Sub-module result_fifo (parameters DEPTH, TAG_W, DATA_W): push/pop, count, full/empty. It is instantiated NUM_SRC times via generate.
- The arbiter and output registers live in cdb_arbiter.

## Test plan
- Reset: hold rst 2 cycles → src_ready = 3'b000 during reset; after release cdb0_valid = cdb1_valid = 0 and src_ready = 3'b111.
- Single result: adder pushes tag 3, value 0x0000_0011 in cycle t → cdb0 = {1, 3, 0x11} in t+2; cdb1_valid = 0; all outputs idle in t+3.
- Three simultaneous results with rr_ptr = 0: add tag 1, mul tag 2, load tag 5 in t → t+2: cdb0 = tag 1, cdb1 = tag 2; t+3: cdb0 = tag 5, cdb1_valid = 0.
- Backpressure: all sources push every cycle for 20 cycles with incrementing values →
  - some src_ready bit deasserts;
  - zero pushes lost;
  - each source's values broadcast in push order;
  - 2 broadcasts per cycle once FIFOs fill.
- Mid-operation reset: fill all FIFOs (6 entries), pulse rst one cycle → no buffered tag ever appears on the CDB; the next push after release is broadcast after 2 cycles.
- Fairness: sources 0–2 continuously valid for 30 cycles → per-source grant counts differ by ≤1 and no source goes 2 consecutive cycles ungranted.
